// File: rtl/axi4lite_master.sv
// AXI4-Lite master bridge: turns a single-beat request/response port into
// one AXI4-Lite read or write transaction at a time.

package axi4lite_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage

module axi4lite_master
  import axi4lite_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  // Request / response port
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_we,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] req_wstrb,
  output logic                      resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic                      busy,
  // AXI4-Lite write address channel
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  // AXI4-Lite write data channel
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  // AXI4-Lite read address channel
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // AXI4-Lite read data channel
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q;
  logic                      aw_done;
  logic                      w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_done_nxt;
  logic w_done_nxt;
  logic bresp_err;
  logic rresp_err;

  // AW and W complete independently; *_nxt folds in a handshake happening now
  // so that both finishing in the same cycle still moves on to WR_RESP.
  assign aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign aw_done_nxt = aw_done || aw_hs;
  assign w_done_nxt  = w_done || w_hs;

  // Error flag is resp[1] (SLVERR or DECERR); EXOKAY counts as success.
  assign bresp_err = (m_axi_bresp == AXI_RESP_SLVERR) || (m_axi_bresp == AXI_RESP_DECERR);
  assign rresp_err = (m_axi_rresp == AXI_RESP_SLVERR) || (m_axi_rresp == AXI_RESP_DECERR);

  // Only IDLE accepts work, and nothing is accepted while reset is applied.
  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // Payloads come straight from the latched request, so they stay stable
  // for as long as the matching valid is high.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;

  // Transaction FSM with registered AXI handshake outputs and response pulse.
  // NOTE: every register here uses <= so all of them update together from
  // the values seen before the edge; blocking = would leak new values into
  // later statements of the same block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_rdata   <= '0;
            resp_err     <= bresp_err;
            state        <= IDLE;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_rdata   <= m_axi_rdata;
            resp_err     <= rresp_err;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: a behavioural AXI4-Lite slave with per-channel
// wait states, a protocol monitor, a directed vector table, hand-written
// back-to-back and reset sequences, and randomized traffic checked against
// a byte-level memory model.

module tb_axi4lite_master;
  import axi4lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axi4lite_master dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .busy          (busy),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk = ~clk;

  // ---------------- scoring ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- slave configuration ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = AXI_RESP_OKAY;
  logic [1:0]  rresp_cfg = AXI_RESP_OKAY;
  bit          rdata_ovr = 1'b0;
  logic [31:0] rdata_ovr_val = 32'h0;

  // ---------------- slave state and statistics ----------------
  logic [31:0] slave_mem [int unsigned];
  bit          aw_hsd, w_hsd, ar_hsd, b_pend, r_pend;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_wait, w_wait, ar_wait;
  logic [31:0] aw_wait_addr, w_wait_data, ar_wait_addr;
  logic [3:0]  w_wait_strb;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_resp = 0, proto_err = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return slave_mem.exists(k) ? slave_mem[k] : 32'h0;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned k;
    logic [31:0] mask;
    k = a >> 2;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    slave_mem[k] = (mem_read(a) & ~mask) | (d & mask);
  endfunction

  // Slave + protocol monitor: acts at every falling edge, so whatever it
  // drives is seen by the DUT at the following rising edge.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid  = 1'b0; m_axi_bresp  = 2'b00;
    m_axi_rvalid  = 1'b0; m_axi_rresp  = 2'b00; m_axi_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0; m_axi_rvalid = 1'b0;
        aw_hsd = 0; w_hsd = 0; ar_hsd = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (resp_valid) n_resp++;
        // A B or R handshake at the last rising edge closes the transaction.
        if (b_pend) begin
          m_axi_bvalid = 1'b0; b_pend = 0;
          aw_hsd = 0; w_hsd = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end
        if (r_pend) begin
          m_axi_rvalid = 1'b0; r_pend = 0;
          ar_hsd = 0; ar_cnt = 0; r_cnt = 0;
        end
        // Address/data handshakes at the last rising edge; valid must be gone now.
        if (m_axi_awready) begin aw_hsd = 1; if (m_axi_awvalid) proto_err++; end
        if (m_axi_wready)  begin w_hsd  = 1; if (m_axi_wvalid)  proto_err++; end
        if (m_axi_arready) begin ar_hsd = 1; if (m_axi_arvalid) proto_err++; end
        // A waiting valid must stay high with an unchanged payload.
        if (aw_wait && (!m_axi_awvalid || m_axi_awaddr !== aw_wait_addr)) proto_err++;
        if (w_wait && (!m_axi_wvalid || m_axi_wdata !== w_wait_data || m_axi_wstrb !== w_wait_strb)) proto_err++;
        if (ar_wait && (!m_axi_arvalid || m_axi_araddr !== ar_wait_addr)) proto_err++;
        // Response-channel readies only after the request side has completed.
        if (m_axi_bready && !(aw_hsd && w_hsd)) proto_err++;
        if (m_axi_rready && !ar_hsd) proto_err++;

        m_axi_awready = 1'b0;
        if (m_axi_awvalid && !aw_hsd) begin
          if (aw_cnt >= aw_delay) begin m_axi_awready = 1'b1; aw_addr_l = m_axi_awaddr; n_aw++; end
          else aw_cnt++;
        end
        aw_wait = m_axi_awvalid && !m_axi_awready;
        aw_wait_addr = m_axi_awaddr;

        m_axi_wready = 1'b0;
        if (m_axi_wvalid && !w_hsd) begin
          if (w_cnt >= w_delay) begin
            m_axi_wready = 1'b1; w_data_l = m_axi_wdata; w_strb_l = m_axi_wstrb; n_w++;
          end else w_cnt++;
        end
        w_wait = m_axi_wvalid && !m_axi_wready;
        w_wait_data = m_axi_wdata;
        w_wait_strb = m_axi_wstrb;

        if (aw_hsd && w_hsd && !m_axi_bvalid) begin
          if (b_cnt >= b_delay) begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; end
          else b_cnt++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_pend = 1; n_b++;
          if (!m_axi_bresp[1]) mem_write(aw_addr_l, w_data_l, w_strb_l);
        end

        m_axi_arready = 1'b0;
        if (m_axi_arvalid && !ar_hsd) begin
          if (ar_cnt >= ar_delay) begin m_axi_arready = 1'b1; ar_addr_l = m_axi_araddr; n_ar++; end
          else ar_cnt++;
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        ar_wait_addr = m_axi_araddr;

        if (ar_hsd && !m_axi_rvalid) begin
          if (r_cnt >= r_delay) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rdata_ovr ? rdata_ovr_val : mem_read(ar_addr_l);
            m_axi_rresp  = rresp_cfg;
          end else r_cnt++;
        end
        if (m_axi_rvalid && m_axi_rready) begin r_pend = 1; n_r++; end
      end
    end
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0] ref_bytes [int unsigned];

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_bytes[a + b] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++)
      if (ref_bytes.exists(a + b)) r = r | (32'(ref_bytes[a + b]) << (8 * b));
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // One request; returns the response, cycles from acceptance to resp_valid,
  // whether it completed, and whether resp_valid was gone the cycle after.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat, output bit ok, output bit single);
    int waitc;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rdata = 32'h0; err = 1'b0; lat = 0; ok = 1'b0; single = 1'b0;
    waitc = 0;
    while (!req_ready && waitc < 100) begin tick(); waitc++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 300) begin tick(); lat++; end
    if (!resp_valid) return;
    ok = 1'b1; rdata = resp_rdata; err = resp_err;
    tick();
    single = !resp_valid;
  endtask

  task automatic set_slave(input int awd, input int wd, input int ard, input int rspd,
                           input logic [1:0] code, input bit ovr, input logic [31:0] ovr_val);
    aw_delay = awd; w_delay = wd; ar_delay = ard; b_delay = rspd; r_delay = rspd;
    bresp_cfg = code; rresp_cfg = code; rdata_ovr = ovr; rdata_ovr_val = ovr_val;
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d, w_d, ar_d, rsp_d;
    logic [1:0]  code;
    bit          ovr;
    logic [31:0] ovr_val;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;    // 0 = latency not checked
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] rd;
    logic        er;
    int          lat, cyc, viol, a0, w0, b0, ar0, r0, resp0, hs_act, hs_exp;
    bit          ok, single;

    vecs[0]  = '{"wr100",      1, 32'h100,   32'h12345678, 4'hF, 0, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 3};
    vecs[1]  = '{"rd100",      0, 32'h100,   32'h0,        4'h0, 0, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h12345678, 0, 3};
    vecs[2]  = '{"wr100_strb", 1, 32'h100,   32'hAABBCCDD, 4'h2, 0, 0, 0, 1, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 0};
    vecs[3]  = '{"rd100_strb", 0, 32'h100,   32'h0,        4'h0, 0, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h1234CC78, 0, 3};
    vecs[4]  = '{"wr200_awwt", 1, 32'h200,   32'h0BADCAFE, 4'hF, 3, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 6};
    vecs[5]  = '{"wr204_wwt",  1, 32'h204,   32'h11223344, 4'hF, 0, 2, 0, 2, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 0};
    vecs[6]  = '{"rd200_slow", 0, 32'h200,   32'h0,        4'h0, 0, 0, 2, 3, AXI_RESP_OKAY,   0, 32'h0,        32'h0BADCAFE, 0, 8};
    vecs[7]  = '{"rd_decerr",  0, 32'h10000, 32'h0,        4'h0, 0, 0, 0, 0, AXI_RESP_DECERR, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 3};
    vecs[8]  = '{"wr_slverr",  1, 32'h10000, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 0, AXI_RESP_SLVERR, 0, 32'h0,        32'h0,        1, 3};
    vecs[9]  = '{"wr_nostrb",  1, 32'h300,   32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 3};
    vecs[10] = '{"rd_nostrb",  0, 32'h300,   32'h0,        4'h0, 0, 0, 0, 0, AXI_RESP_OKAY,   0, 32'h0,        32'h0,        0, 3};
    vecs[11] = '{"rd_exokay",  0, 32'h100,   32'h0,        4'h0, 0, 0, 0, 0, AXI_RESP_EXOKAY, 0, 32'h0,        32'h1234CC78, 0, 3};

    // ---- reset state ----
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    check("rst_resp", {resp_valid, resp_err}, 0);
    check("rst_rdata", resp_rdata, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", req_ready, 1);
    tick();

    // ---- directed vector table ----
    for (int i = 0; i < 12; i++) begin
      set_slave(vecs[i].aw_d, vecs[i].w_d, vecs[i].ar_d, vecs[i].rsp_d, vecs[i].code,
                vecs[i].ovr, vecs[i].ovr_val);
      a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; resp0 = n_resp;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lat, ok, single);
      check({vecs[i].name, "_done"}, ok, 1);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, er, vecs[i].exp_err);
      check({vecs[i].name, "_pulse1"}, single, 1);
      if (vecs[i].exp_lat != 0) check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      hs_act = (n_aw - a0) * 10000 + (n_w - w0) * 1000 + (n_b - b0) * 100 + (n_ar - ar0) * 10 + (n_r - r0);
      hs_exp = vecs[i].we ? 11100 : 11;
      check({vecs[i].name, "_handshakes"}, hs_act, hs_exp);
      check({vecs[i].name, "_resp_count"}, n_resp - resp0, 1);
      check({vecs[i].name, "_protocol"}, proto_err, 0);
    end

    // ---- back-to-back: req_valid held across a read then a write ----
    set_slave(0, 0, 0, 0, AXI_RESP_OKAY, 0, 32'h0);
    resp0 = n_resp; viol = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_wdata = 32'h0; req_wstrb = 4'h0;
    cyc = 0;
    while (!req_ready && cyc < 100) begin tick(); cyc++; end
    tick();
    req_we = 1'b1; req_addr = 32'h500; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    cyc = 0;
    while (!resp_valid && cyc < 100) begin if (req_ready || !busy) viol++; tick(); cyc++; end
    check("b2b_first_resp", resp_valid, 1);
    check("b2b_first_rdata", resp_rdata, 32'h1234CC78);
    check("b2b_first_err", resp_err, 0);
    check("b2b_ready_at_resp", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("b2b_second_accepted", busy, 1);
    cyc = 0;
    while (!resp_valid && cyc < 100) begin if (req_ready || !busy) viol++; tick(); cyc++; end
    check("b2b_second_resp", resp_valid, 1);
    check("b2b_second_rdata", resp_rdata, 0);
    check("b2b_second_err", resp_err, 0);
    check("b2b_ready_busy", viol, 0);
    tick();
    check("b2b_resp_count", n_resp - resp0, 2);
    do_req(1'b0, 32'h500, 32'h0, 4'h0, rd, er, lat, ok, single);
    check("b2b_readback", rd, 32'hCAFEF00D);

    // ---- reset while waiting in RD_RESP ----
    set_slave(0, 0, 0, 100000, AXI_RESP_OKAY, 0, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h104;
    cyc = 0;
    while (!req_ready && cyc < 100) begin tick(); cyc++; end
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (!m_axi_rready && cyc < 50) begin tick(); cyc++; end
    check("rst_mid_in_rd_resp", {busy, m_axi_rready}, 2'b11);
    resp0 = n_resp;
    rst = 1'b1;
    tick();
    check("rst_mid_arvalid", m_axi_arvalid, 0);
    check("rst_mid_rready", m_axi_rready, 0);
    check("rst_mid_resp_valid", resp_valid, 0);
    check("rst_mid_rdata", resp_rdata, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_req_ready", req_ready, 0);
    rst = 1'b0;
    r_delay = 0; b_delay = 0;
    #1;
    check("rst_mid_ready_after", req_ready, 1);
    tick();
    check("rst_mid_no_resp", n_resp - resp0, 0);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, er, lat, ok, single);
    check("rst_mid_read_ok", {ok, er}, 2'b10);
    check("rst_mid_read_data", rd, 32'h1234CC78);

    // ---- randomized traffic against the byte-level model ----
    for (int t = 0; t < 60; t++) begin
      bit          r_we;
      logic [31:0] r_addr, r_data, exp_rd;
      logic [3:0]  r_strb;
      logic [1:0]  r_code;
      bit          exp_er;
      r_we   = ($urandom_range(0, 1) == 1);
      r_addr = 32'h400 + 32'(4 * $urandom_range(0, 7));
      r_data = $urandom();
      r_strb = 4'($urandom_range(0, 15));
      r_code = 2'($urandom_range(0, 3));
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), r_code, 0, 32'h0);
      exp_er = (r_code == AXI_RESP_SLVERR) || (r_code == AXI_RESP_DECERR);
      exp_rd = r_we ? 32'h0 : ref_read(r_addr);
      if (r_we && !exp_er) ref_write(r_addr, r_data, r_strb);
      do_req(r_we, r_addr, r_data, r_strb, rd, er, lat, ok, single);
      check($sformatf("rand%0d_done", t), {ok, single}, 2'b11);
      check($sformatf("rand%0d_rdata", t), rd, exp_rd);
      check($sformatf("rand%0d_err", t), er, exp_er);
    end
    check("final_protocol", proto_err, 0);
    check("final_hs_balance", (n_aw == n_b) && (n_w == n_b) && (n_ar == n_r + 1), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
